// File: rtl/move_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// move_scheduler_pkg
// Shared game constants: direction codes used by both the move scheduler and
// the collision checker, the scheduler FSM state type, and small helpers for
// button decoding and saturating position steps.
// -----------------------------------------------------------------------------
package move_scheduler_pkg;

  // Direction codes. Horizontal and vertical axes share the same encoding:
  // 1 means "towards larger coordinate" and 2 means "towards smaller".
  localparam logic [1:0] DIR_NONE  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;

  localparam logic [9:0] POS_MAX = 10'h3FF;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_X_CLR   = 4'd1,
    S_X_START = 4'd2,
    S_X_WAIT  = 4'd3,
    S_X_APPLY = 4'd4,
    S_Y_CLR   = 4'd5,
    S_Y_START = 4'd6,
    S_Y_WAIT  = 4'd7,
    S_Y_APPLY = 4'd8
  } state_t;

  // Decode one axis from its two opposing buttons; both or neither -> NONE.
  function automatic logic [1:0] dir_decode(input logic inc_btn, input logic dec_btn);
    logic [1:0] dir;
    case ({inc_btn, dec_btn})
      2'b10:   dir = DIR_RIGHT;
      2'b01:   dir = DIR_LEFT;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  // Move a coordinate by step in the given direction, clamping to [0, POS_MAX].
  function automatic logic [9:0] step_pos(input logic [9:0] pos,
                                          input logic [1:0] dir,
                                          input logic [9:0] step);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = {1'b0, pos} + {1'b0, step};
    case (dir)
      DIR_RIGHT: res = sum[10] ? POS_MAX : sum[9:0];
      DIR_LEFT:  res = (pos < step) ? 10'd0 : (pos - step);
      default:   res = pos;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// -----------------------------------------------------------------------------
// move_scheduler_if
// Link between the move scheduler (master) and the collision checker (slave).
//   lim_rst_n  master->slave  active-low restart of the checker
//   lim_start  master->slave  one-cycle check start
//   lim_l_r    master->slave  horizontal direction under test
//   lim_u_d    master->slave  vertical direction under test
//   x_pos      master->slave  current player x (top-left pixel)
//   y_pos      master->slave  current player y (top-left pixel)
//   lim_done   slave->master  check finished, sticky until lim_rst_n pulse
//   lim_valid  slave->master  verdict, meaningful while lim_done=1
// -----------------------------------------------------------------------------
interface move_scheduler_if;
  logic       lim_rst_n;
  logic       lim_start;
  logic [1:0] lim_l_r;
  logic [1:0] lim_u_d;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       lim_done;
  logic       lim_valid;

  modport master (
    output lim_rst_n, lim_start, lim_l_r, lim_u_d, x_pos, y_pos,
    input  lim_done, lim_valid
  );

  modport slave (
    input  lim_rst_n, lim_start, lim_l_r, lim_u_d, x_pos, y_pos,
    output lim_done, lim_valid
  );
endinterface

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
// On each frame tick, samples the direction buttons and asks the collision
// checker about the x move, then the y move, committing each accepted move to
// the player position. Rejected or timed-out moves leave the position alone and
// flag the axis in blocked.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   tick       one-cycle frame strobe (ignored while busy)
//   btn_*      level movement requests
//   lim        checker link (master side), also carries x_pos / y_pos
//   busy       high whenever the FSM is not in IDLE
//   blocked    bit0: last x attempt failed, bit1: last y attempt failed
// -----------------------------------------------------------------------------
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter logic [9:0] X_INIT  = 10'd150,
  parameter logic [9:0] Y_INIT  = 10'd70,
  parameter logic [9:0] STEP    = 10'd1,
  parameter logic [5:0] TIMEOUT = 6'd40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_up,
  input  logic                    btn_down,
  move_scheduler_if.master        lim,
  output logic                    busy,
  output logic [1:0]              blocked
);

  state_t     r_state;
  logic [1:0] r_dx;
  logic [1:0] r_dy;
  logic [5:0] r_cnt;
  logic       r_ok;
  logic [9:0] r_x_pos;
  logic [9:0] r_y_pos;
  logic       r_lim_rst_n;
  logic       r_lim_start;
  logic [1:0] r_lim_l_r;
  logic [1:0] r_lim_u_d;
  logic       r_busy;
  logic [1:0] r_blocked;

  logic [1:0] w_dx;
  logic [1:0] w_dy;
  logic       w_wait_exit;

  assign w_dx = dir_decode(btn_right, btn_left);
  assign w_dy = dir_decode(btn_down, btn_up);

  // The wait ends on the checker's done flag or after TIMEOUT cycles in WAIT.
  assign w_wait_exit = lim.lim_done | ((r_cnt + 6'd1) == TIMEOUT);

  // Scheduler FSM; every output is a register updated with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dx        <= DIR_NONE;
      r_dy        <= DIR_NONE;
      r_cnt       <= 6'd0;
      r_ok        <= 1'b0;
      r_x_pos     <= X_INIT;
      r_y_pos     <= Y_INIT;
      r_lim_rst_n <= 1'b0;
      r_lim_start <= 1'b0;
      r_lim_l_r   <= DIR_NONE;
      r_lim_u_d   <= DIR_NONE;
      r_busy      <= 1'b0;
      r_blocked   <= 2'b00;
    end else begin
      // Strobes default inactive; only CLR/START entries pulse them.
      r_lim_rst_n <= 1'b1;
      r_lim_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tick) begin
            r_dx <= w_dx;
            r_dy <= w_dy;
            if (w_dx != DIR_NONE) begin
              r_state     <= S_X_CLR;
              r_busy      <= 1'b1;
              r_lim_rst_n <= 1'b0;
              r_lim_l_r   <= w_dx;
              r_lim_u_d   <= DIR_NONE;
            end else if (w_dy != DIR_NONE) begin
              r_state     <= S_Y_CLR;
              r_busy      <= 1'b1;
              r_lim_rst_n <= 1'b0;
              r_lim_l_r   <= DIR_NONE;
              r_lim_u_d   <= w_dy;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_X_CLR: begin
          r_state     <= S_X_START;
          r_lim_start <= 1'b1;
        end

        S_X_START: begin
          r_state <= S_X_WAIT;
          r_cnt   <= 6'd0;
        end

        S_X_WAIT: begin
          if (w_wait_exit) begin
            r_state <= S_X_APPLY;
            // A timeout has lim_done low, so it is treated as a rejection.
            r_ok    <= lim.lim_done & lim.lim_valid;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_X_APPLY: begin
          if (r_ok) begin
            r_x_pos      <= step_pos(r_x_pos, r_dx, STEP);
            r_blocked[0] <= 1'b0;
          end else begin
            r_blocked[0] <= 1'b1;
          end
          if (r_dy != DIR_NONE) begin
            r_state     <= S_Y_CLR;
            r_lim_rst_n <= 1'b0;
            r_lim_l_r   <= DIR_NONE;
            r_lim_u_d   <= r_dy;
          end else begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_lim_l_r <= DIR_NONE;
            r_lim_u_d <= DIR_NONE;
          end
        end

        S_Y_CLR: begin
          r_state     <= S_Y_START;
          r_lim_start <= 1'b1;
        end

        S_Y_START: begin
          r_state <= S_Y_WAIT;
          r_cnt   <= 6'd0;
        end

        S_Y_WAIT: begin
          if (w_wait_exit) begin
            r_state <= S_Y_APPLY;
            r_ok    <= lim.lim_done & lim.lim_valid;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_Y_APPLY: begin
          if (r_ok) begin
            r_y_pos      <= step_pos(r_y_pos, r_dy, STEP);
            r_blocked[1] <= 1'b0;
          end else begin
            r_blocked[1] <= 1'b1;
          end
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_lim_l_r <= DIR_NONE;
          r_lim_u_d <= DIR_NONE;
        end

        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_lim_l_r <= DIR_NONE;
          r_lim_u_d <= DIR_NONE;
        end
      endcase
    end
  end

  assign lim.lim_rst_n = r_lim_rst_n;
  assign lim.lim_start = r_lim_start;
  assign lim.lim_l_r   = r_lim_l_r;
  assign lim.lim_u_d   = r_lim_u_d;
  assign lim.x_pos     = r_x_pos;
  assign lim.y_pos     = r_y_pos;
  assign busy          = r_busy;
  assign blocked       = r_blocked;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
// Drives directed move requests into move_scheduler with a behavioural checker
// stub. Expected results are queued when a request is issued and compared by a
// monitor when busy falls.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

  localparam int STUB_LAT = 11;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] blk;
    int         cyc;
    int         pulses;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       tick2 = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       busy;
  logic       busy2;
  logic [1:0] blocked;
  logic [1:0] blocked2;

  // Stub verdict per axis: 0 accept, 1 reject, 2 never finish.
  int x_mode = 0;
  int y_mode = 0;

  int checks = 0;
  int errors = 0;
  int mon_cyc = 0;
  int mon_pulses = 0;
  exp_t sb_q[$];

  move_scheduler_if sif();
  move_scheduler_if sif2();

  move_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .lim(sif), .busy(busy), .blocked(blocked)
  );

  move_scheduler #(.X_INIT(10'd0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick2),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .lim(sif2), .busy(busy2), .blocked(blocked2)
  );

  always #5 clk = ~clk;

  // Checker stub for the main DUT: verdict STUB_LAT cycles after start is seen.
  int  stub_cnt;
  int  stub_mode;
  logic stub_armed;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sif.lim_done  <= 1'b0;
      sif.lim_valid <= 1'b0;
      stub_armed    <= 1'b0;
      stub_cnt      <= 0;
      stub_mode     <= 0;
    end else if (!sif.lim_rst_n) begin
      sif.lim_done  <= 1'b0;
      sif.lim_valid <= 1'b0;
      stub_armed    <= 1'b0;
      stub_cnt      <= 0;
    end else if (sif.lim_start) begin
      stub_armed <= 1'b1;
      stub_cnt   <= 0;
      stub_mode  <= (sif.lim_l_r != 2'd0) ? x_mode : y_mode;
    end else if (stub_armed && stub_cnt == STUB_LAT - 1) begin
      stub_armed <= 1'b0;
      if (stub_mode != 2) begin
        sif.lim_done  <= 1'b1;
        sif.lim_valid <= (stub_mode == 0);
      end
    end else if (stub_armed) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  // Checker stub for the saturation DUT: always accepts one cycle after start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sif2.lim_done <= 1'b0;
    else if (!sif2.lim_rst_n) sif2.lim_done <= 1'b0;
    else if (sif2.lim_start)  sif2.lim_done <= 1'b1;
  end
  assign sif2.lim_valid = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_x_pos", 32'(sif.x_pos), 32'd150);
    check("rst_y_pos", 32'(sif.y_pos), 32'd70);
    check("rst_lim_rst_n", 32'(sif.lim_rst_n), 32'd0);
    check("rst_lim_start", 32'(sif.lim_start), 32'd0);
    check("rst_lim_l_r", 32'(sif.lim_l_r), 32'd0);
    check("rst_lim_u_d", 32'(sif.lim_u_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blocked", 32'(blocked), 32'd0);
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [1:0] blk,
                          input int cyc, input int pulses);
    exp_t e;
    e.x = x; e.y = y; e.blk = blk; e.cyc = cyc; e.pulses = pulses;
    sb_q.push_back(e);
  endtask

  // Count busy cycles (expects 0) over n negedges.
  task automatic expect_quiet(input string name, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check(name, 32'(hi), 32'd0);
  endtask

  // Monitor: measures each evaluation and compares it when busy falls.
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_busy  = 1'b0;
        mon_cyc    = 0;
        mon_pulses = 0;
      end else begin
        if (busy) mon_cyc++;
        if (!sif.lim_rst_n) mon_pulses++;
        if (prev_busy && !busy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_eval", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("x_pos", 32'(sif.x_pos), 32'(e.x));
            check("y_pos", 32'(sif.y_pos), 32'(e.y));
            check("blocked", 32'(blocked), 32'(e.blk));
            check("busy_cycles", 32'(mon_cyc), 32'(e.cyc));
            check("lim_rst_n_pulses", 32'(mon_pulses), 32'(e.pulses));
          end
          mon_cyc    = 0;
          mon_pulses = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stimulus
    #1 rst = 1'b0;
    #1 check_reset_vals();
    check("rst_sat_x_pos", 32'(sif2.x_pos), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    check("lim_rst_n_release", 32'(sif.lim_rst_n), 32'd1);

    // Saturation at x=0 on the second instance.
    btn_left = 1'b1;
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy2) break;
      @(negedge clk);
    end
    check("sat_done", 32'(busy2), 32'd0);
    check("sat_x_pos", 32'(sif2.x_pos), 32'd0);
    check("sat_blocked", 32'(blocked2), 32'd0);
    check("sat_y_pos", 32'(sif2.y_pos), 32'd70);
    btn_left = 1'b0;

    // Right, accepted; a tick mid-evaluation must be dropped.
    btn_right = 1'b1;
    push_exp(10'd151, 10'd70, 2'b00, 15, 1);
    do_tick();
    repeat (4) @(negedge clk);
    do_tick();
    wait_idle();
    btn_right = 1'b0;
    expect_quiet("no_queued_tick", 8);

    // Up+left: x rejected, y accepted; buttons change after latching.
    btn_up = 1'b1; btn_left = 1'b1;
    x_mode = 1; y_mode = 0;
    push_exp(10'd151, 10'd69, 2'b01, 30, 2);
    do_tick();
    btn_up = 1'b0; btn_left = 1'b0; btn_down = 1'b1; btn_right = 1'b1;
    wait_idle();
    btn_down = 1'b0; btn_right = 1'b0;
    x_mode = 0;

    // Opposing buttons: no evaluation at all.
    btn_left = 1'b1; btn_right = 1'b1;
    do_tick();
    expect_quiet("opposing_busy", 6);
    check("opposing_pulses", 32'(mon_pulses), 32'd0);
    check("opposing_x", 32'(sif.x_pos), 32'd151);
    check("opposing_y", 32'(sif.y_pos), 32'd69);
    btn_left = 1'b0; btn_right = 1'b0;

    // Right+down, both accepted; clears blocked[0].
    btn_right = 1'b1; btn_down = 1'b1;
    push_exp(10'd152, 10'd70, 2'b00, 30, 2);
    do_tick();
    wait_idle();
    btn_right = 1'b0; btn_down = 1'b0;

    // Right with a checker that never finishes: timeout after 40 wait cycles.
    btn_right = 1'b1; x_mode = 2;
    push_exp(10'd152, 10'd70, 2'b01, 43, 1);
    do_tick();
    wait_idle();
    btn_right = 1'b0;

    // Reset during X_WAIT, with an extra tick issued while busy.
    btn_right = 1'b1;
    do_tick();
    repeat (6) @(negedge clk);
    do_tick();
    repeat (2) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_vals();
    @(negedge clk); #2 rst = 1'b1;
    btn_right = 1'b0; x_mode = 0;
    expect_quiet("post_reset_quiet", 20);
    check("post_reset_pulses", 32'(mon_pulses), 32'd0);
    check("post_reset_lim_rst_n", 32'(sif.lim_rst_n), 32'd1);

    // Normal operation after reset.
    btn_right = 1'b1;
    push_exp(10'd151, 10'd70, 2'b00, 15, 1);
    do_tick();
    wait_idle();
    btn_right = 1'b0;
    @(negedge clk);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter X_INIT, default 10'd150: player x-position after reset.
REQ-002 Parameter Y_INIT, default 10'd70: player y-position after reset.
REQ-003 Parameter STEP, default 10'd1: pixels moved per accepted axis move.
REQ-004 Parameter TIMEOUT, default 6'd40: maximum cycles spent waiting for lim_done.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 tick  in  1  one-cycle frame strobe that requests one movement evaluation.
REQ-008 btn_left, btn_right, btn_up, btn_down  in  1 each  level movement requests.
REQ-009 lim_rst_n  out  1  active-low restart to the collision checker.
REQ-010 lim_start  out  1  collision-check start.
REQ-011 lim_l_r  out  2  horizontal direction to the checker: 0 none, 1 right, 2 left.
REQ-012 lim_u_d  out  2  vertical direction to the checker: 0 none, 1 down, 2 up.
REQ-013 lim_done  in  1  checker finished; sticky until lim_rst_n is pulsed.
REQ-014 lim_valid  in  1  checker verdict; meaningful only while lim_done=1.
REQ-015 x_pos, y_pos  out  10 each  current player top-left pixel; also feed the checker.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 blocked  out  2  bit0 = last x attempt rejected or timed out; bit1 = same for y.

Function
REQ-018 FSM states SHALL be IDLE, X_CLR, X_START, X_WAIT, X_APPLY, Y_CLR, Y_START, Y_WAIT, Y_APPLY.
REQ-019 On tick in IDLE, the block SHALL latch dx (right-only -> 1, left-only -> 2, otherwise 0) and dy (down-only -> 1, up-only -> 2, otherwise 0).
REQ-020 Opposing buttons pressed together SHALL give direction 0 for that axis.
REQ-021 If dx is nonzero, the next state SHALL be X_CLR; else if dy is nonzero, Y_CLR; else the FSM stays in IDLE.
REQ-022 X_CLR SHALL drive lim_rst_n=0 for exactly one cycle, with lim_l_r=dx and lim_u_d=0; the next state is X_START.
REQ-023 X_START SHALL drive lim_start=1 for exactly one cycle; the next state is X_WAIT.
REQ-024 X_WAIT SHALL hold lim_l_r and lim_u_d, count cycles, and go to X_APPLY when lim_done=1 or when the count reaches TIMEOUT.
REQ-025 X_APPLY, when lim_done=1 and lim_valid=1, SHALL update x_pos by +STEP (dx=1) or -STEP (dx=2), saturating at 0 and 10'h3FF, and SHALL clear blocked[0].
REQ-026 X_APPLY, on a rejection or a timeout, SHALL leave x_pos unchanged and set blocked[0].
REQ-027 After X_APPLY the FSM SHALL go to Y_CLR if dy is nonzero, else to IDLE.
REQ-028 The Y states SHALL mirror the X states: lim_l_r=0, lim_u_d=dy, and updates to y_pos and blocked[1].
REQ-029 x_pos and y_pos SHALL change only in the APPLY states and SHALL stay stable while the checker runs.
REQ-030 A tick arriving while busy=1 SHALL be ignored, with no queueing.
REQ-031 Button changes after the tick is latched SHALL NOT affect the evaluation in progress.
REQ-032 All outputs SHALL be registered; lim_rst_n SHALL be 1 outside the CLR states, and lim_start SHALL be 0 outside the START states.
REQ-033 Without a timeout, one axis SHALL take 3 cycles plus the checker latency plus 1 cycle; with the standard checker this is 15 cycles per axis.

Reset
REQ-034 When rst=0, the block SHALL asynchronously force: state IDLE, x_pos=X_INIT, y_pos=Y_INIT, lim_rst_n=0, lim_start=0, lim_l_r=0, lim_u_d=0, busy=0, blocked=0, wait counter=0.
REQ-035 After release, lim_rst_n SHALL return to 1 on the first clock.
REQ-036 A reset in the middle of an evaluation SHALL abandon it, with no partial position update.

Structure
REQ-037 The direction codes (NONE=0, RIGHT/DOWN=1, LEFT/UP=2) SHALL live in the shared game constants include used by the collision checker.
REQ-038 The block SHALL be a single module with no sub-modules; the checker is instantiated beside it at top level.

Verification
REQ-039 Reset, then tick with btn_right=1 and a checker stub returning valid after 11 cycles -> x_pos 150 -> 151, y_pos stays 70, blocked=00, busy high for 15 cycles.
REQ-040 tick with btn_up=1 and btn_left=1, stub rejecting x and accepting y -> x_pos unchanged, y_pos decremented by 1, blocked=01, and exactly two lim_rst_n pulses.
REQ-041 tick with btn_left=1 and btn_right=1 only -> no lim_rst_n pulse, busy stays 0, position unchanged.
REQ-042 Stub never asserts lim_done -> X_WAIT exits after 40 cycles, blocked[0]=1, position unchanged, FSM returns to IDLE.
REQ-043 X_INIT=0, tick with btn_left=1 and stub valid -> x_pos stays 0 (saturated).
REQ-044 rst asserted during X_WAIT, plus a second tick issued while busy -> on reset, outputs return to REQ-034 values immediately; the second tick produces no extra evaluation.
